// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command sequencer: opcodes, FSM states and
// the command-legality screen.
package alu_pkg;

  localparam int unsigned ALU_WIDTH = 8;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_DIV = 3'b011;
  localparam logic [2:0] OP_MOD = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_RESP
  } seq_state_e;

  // Undefined opcodes and a zero divisor for div/mod never reach the ALU.
  function automatic logic cmd_is_illegal(input logic [2:0] op, input logic b_is_zero);
    logic undefined_op;
    logic div_by_zero;
    undefined_op = (op > OP_MOD);
    div_by_zero  = ((op == OP_DIV) || (op == OP_MOD)) && b_is_zero;
    return undefined_op || div_by_zero;
  endfunction

endpackage

// File: rtl/alu_settle_timer.sv
// 4-bit load/decrement counter timing how long ALU inputs are held before the
// result is sampled.
module alu_settle_timer
  import alu_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       load_i,
  input  logic [3:0] load_val_i,
  input  logic       dec_i,
  output logic [3:0] cnt_o,
  output logic       zero_o
);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_o <= '0;
    end else if (load_i) begin
      cnt_o <= load_val_i;
    end else if (dec_i && (cnt_o != '0)) begin
      cnt_o <= cnt_o - 4'd1;
    end
  end

  assign zero_o = (cnt_o == '0);

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Initiator for the combinational ALU: accepts (op, A, B) commands, drives the
// ALU, waits SETTLE_CYCLES and returns the sampled result or an error flag.
module alu_cmd_sequencer
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH         = ALU_WIDTH,
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic [2:0]       cmd_op_i,
  input  logic [WIDTH-1:0] cmd_a_i,
  input  logic [WIDTH-1:0] cmd_b_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [WIDTH-1:0] rsp_data_o,
  output logic             rsp_err_o,
  output logic [WIDTH-1:0] alu_data0_o,
  output logic [WIDTH-1:0] alu_data1_o,
  output logic [2:0]       alu_ctrl_o,
  input  logic [WIDTH-1:0] alu_result_i,
  output logic [7:0]       done_cnt_o
);

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

  seq_state_e state;
  logic       cmd_illegal;
  logic       cmd_accept;
  logic       timer_load;
  logic       timer_dec;
  logic [3:0] timer_cnt;
  logic       timer_zero;

  assign cmd_illegal = cmd_is_illegal(cmd_op_i, cmd_b_i == '0);
  assign cmd_accept  = (state == ST_IDLE) && cmd_valid_i && cmd_ready_o;
  assign timer_load  = cmd_accept && !cmd_illegal;
  assign timer_dec   = (state == ST_DRIVE);

  alu_settle_timer u_settle_timer (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (timer_load),
    .load_val_i (SETTLE_LOAD),
    .dec_i      (timer_dec),
    .cnt_o      (timer_cnt),
    .zero_o     (timer_zero)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= ST_IDLE;
      cmd_ready_o <= 1'b1;
      rsp_valid_o <= 1'b0;
      rsp_data_o  <= '0;
      rsp_err_o   <= 1'b0;
      alu_data0_o <= '0;
      alu_data1_o <= '0;
      alu_ctrl_o  <= '0;
      done_cnt_o  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_accept) begin
            cmd_ready_o <= 1'b0;
            if (cmd_illegal) begin
              rsp_data_o  <= '0;
              rsp_err_o   <= 1'b1;
              rsp_valid_o <= 1'b1;
              state       <= ST_RESP;
            end else begin
              alu_data0_o <= cmd_a_i;
              alu_data1_o <= cmd_b_i;
              alu_ctrl_o  <= cmd_op_i;
              state       <= ST_DRIVE;
            end
          end
        end
        ST_DRIVE: begin
          if (timer_zero) begin
            rsp_data_o  <= alu_result_i;
            rsp_err_o   <= 1'b0;
            rsp_valid_o <= 1'b1;
            state       <= ST_RESP;
          end
        end
        ST_RESP: begin
          // Ready is re-raised registered, so no command is taken on the handshake edge.
          if (rsp_ready_i) begin
            rsp_valid_o <= 1'b0;
            done_cnt_o  <= done_cnt_o + 8'd1;
            cmd_ready_o <= 1'b1;
            state       <= ST_IDLE;
          end
        end
        default: begin
          state       <= ST_IDLE;
          cmd_ready_o <= 1'b1;
        end
      endcase
    end
  end

endmodule
